fsm_escribir_rtc: RTL
=====================

Name: fsm_escribir_rtc

Overview:
Write-side controller for the RTC's multiplexed address/data bus. It is the counterpart of the existing read FSM. On a start request it writes one register group (date, time or timer) into the RTC: three address/data write transactions, followed by a write of the command/transfer register that commits the group. It sits between the user-side register bank, which it indexes through reg_idx/dato_reg, and the tri-state bus buffer driven by buffer_activo.

Parameters:
T_ESPERA, 2, cycles for each setup phase and each hold phase (minimum 1).
T_PULSO, 4, cycles wr is held low per strobe (minimum 1).

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-high reset.
do_it_escribir  input  1  start request; rising edge is detected internally.
sel_grupo  input  2  group to write: 0 = fecha (dia, mes, anio), 1 = hora (seg, min, hora), 2 = timer (seg_tim, min_tim, hora_tim), 3 = invalid.
dato_reg  input  8  BCD data for the register currently selected by reg_idx.
reg_idx  output  4  register select into the user bank: 0 seg, 1 min, 2 hora, 3 dia, 4 mes, 5 anio, 6 seg_tim, 7 min_tim, 8 hora_tim, 9 comando.
a_d  output  1  0 = address phase, 1 = data phase.
cs  output  1  chip select, active-low.
rd  output  1  read strobe, active-low; held at 1 at all times.
wr  output  1  write strobe, active-low.
bus_out  output  8  byte driven onto the RTC bus.
buffer_activo  output  1  1 = tri-state buffer drives bus_out.
ocupado  output  1  1 while a sequence is in progress.
listo  output  1  one-cycle pulse when a sequence completes.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-transaction):
  - cs = 1, rd = 1, wr = 1, a_d = 1.
  - bus_out = 0x00, buffer_activo = 0, reg_idx = 0, ocupado = 0, listo = 0.
  - State returns to IDLE and the edge detector's previous-value register is set to 1, so a do_it_escribir held high through reset does not trigger a start.
- Start: a start occurs when the state is IDLE, do_it_escribir = 1, the registered previous value = 0, and sel_grupo is not 3.
  - sel_grupo is latched at start.
  - On the next cycle ocupado = 1 and the first ADDR_SETUP begins.
  - sel_grupo = 3: no bus activity and no listo pulse.
  - Edges that arrive while ocupado = 1 are ignored and are not queued.
- Register order per group:
  - fecha: 3, 4, 5, then comando.
  - hora: 0, 1, 2, then comando.
  - timer: 6, 7, 8, then comando.
- Addresses: seg 0x21, min 0x22, hora 0x23, dia 0x24, mes 0x25, anio 0x26, seg_tim 0x41, min_tim 0x42, hora_tim 0x43, comando 0xF0.
- Command data: 0xF1 for the fecha and hora groups, 0xF2 for the timer group. dato_reg is ignored when reg_idx = 9.
- Per-transaction states, with E = T_ESPERA and P = T_PULSO. A 1-cycle GAP follows the last phase.
  - ADDR_SETUP (E cycles): cs = 0, a_d = 0, wr = 1, buffer_activo = 1, bus_out = address.
  - ADDR_STROBE (P cycles): same as ADDR_SETUP, but wr = 0.
  - ADDR_HOLD (E cycles): same as ADDR_SETUP, wr = 1.
  - DATA_SETUP (E cycles): a_d = 1, bus_out = data. dato_reg is captured into an internal register on the first cycle and held through DATA_HOLD.
  - DATA_STROBE (P cycles): wr = 0.
  - DATA_HOLD (E cycles): wr = 1.
  - GAP (1 cycle): cs = 1, buffer_activo = 0, a_d = 1, bus_out = 0x00.
- Transaction length is 4E + 2P + 1 cycles (17 with default parameters).
- reg_idx changes to the current register on the first ADDR_SETUP cycle of its transaction and stays stable until the next transaction starts.
- Bus ordering:
  - wr never falls in the same cycle that a_d, bus_out or cs changes.
  - cs never rises while wr = 0.
  - rd is never 0.
- Completion: after the GAP of the command transaction, the next cycle holds listo = 1 and ocupado = 0, and the state returns to IDLE.
  - A new start may be detected in the same cycle as listo if a fresh rising edge occurs.
- Full sequence with default parameters: 4 × 17 = 68 ocupado cycles, then the listo pulse.

Test Plan:
1. Reset held 100 ns with do_it_escribir = 1, then released -> no start occurs; all outputs stay at their reset values, cs = 1, ocupado = 0.
2. sel_grupo = 1, dato_reg returns 0x45/0x30/0x12 for reg_idx 0/1/2, rising edge on do_it_escribir:
   - Bus writes are (0x21, 0x45), (0x22, 0x30), (0x23, 0x12), (0xF0, 0xF1).
   - Each wr low pulse lasts 4 cycles.
   - ocupado = 1 for exactly 68 cycles, then listo = 1 for 1 cycle.
3. sel_grupo = 2 with data 0x10/0x05/0x01 -> bus writes are (0x41, 0x10), (0x42, 0x05), (0x43, 0x01), (0xF0, 0xF2); rd stays 1 throughout.
4. Second rising edge on do_it_escribir during the 2nd transaction -> ignored; exactly 4 transactions and a single listo pulse occur.
5. reset asserted during the DATA_STROBE of the 2nd transaction -> in the same cycle wr = 1, cs = 1 and buffer_activo = 0; no listo pulse; a new edge afterwards restarts the sequence from the first register.
6. sel_grupo = 3 with a rising edge -> no cs activity and no listo. Then, with T_ESPERA = 1 and T_PULSO = 1, a fecha write -> each transaction lasts 7 cycles and the address is 0x24 first.

Source files
------------

// File: rtl/fsm_escribir_rtc.sv
// Write controller for the RTC multiplexed address/data bus: writes one register group
// (three address/data transactions) and then the command register that commits it.
module fsm_escribir_rtc #(
  parameter int unsigned T_ESPERA = 2,
  parameter int unsigned T_PULSO  = 4
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_do_it_escribir,
  input  logic [1:0] i_sel_grupo,
  input  logic [7:0] i_dato_reg,
  output logic [3:0] o_reg_idx,
  output logic       o_a_d,
  output logic       o_cs,
  output logic       o_rd,
  output logic       o_wr,
  output logic [7:0] o_bus_out,
  output logic       o_buffer_activo,
  output logic       o_ocupado,
  output logic       o_listo
);

  localparam int unsigned CntMax = (T_ESPERA > T_PULSO) ? T_ESPERA : T_PULSO;
  localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;
  localparam logic [CntW-1:0] FinE = CntW'(T_ESPERA - 1);
  localparam logic [CntW-1:0] FinP = CntW'(T_PULSO - 1);

  localparam logic [3:0] IdxComando = 4'd9;
  localparam logic [7:0] CmdFechaHora = 8'hF1;
  localparam logic [7:0] CmdTimer     = 8'hF2;

  typedef enum logic [2:0] {
    StIdle,
    StAddrSetup,
    StAddrStrobe,
    StAddrHold,
    StDataSetup,
    StDataStrobe,
    StDataHold,
    StGap
  } state_t;

  state_t          r_state;
  logic [CntW-1:0] r_cnt;
  logic [1:0]      r_txn;
  logic [1:0]      r_grupo;
  logic            r_prev;
  logic [3:0]      r_reg_idx;
  logic            r_a_d;
  logic            r_cs;
  logic            r_wr;
  logic [7:0]      r_bus;
  logic            r_buf;
  logic            r_ocupado;
  logic            r_listo;

  logic            w_start;
  logic            w_fin_e;
  logic            w_fin_p;
  logic [1:0]      w_txn_next;
  logic [3:0]      w_idx_first;
  logic [3:0]      w_idx_next;
  logic [7:0]      w_dato;

  // Register visited by transaction txn of a group; the fourth is always the command.
  function automatic logic [3:0] f_reg_idx(input logic [1:0] grupo, input logic [1:0] txn);
    logic [3:0] base;
    case (grupo)
      2'd0:    base = 4'd3;
      2'd1:    base = 4'd0;
      default: base = 4'd6;
    endcase
    return (txn == 2'd3) ? IdxComando : base + {2'b00, txn};
  endfunction

  function automatic logic [7:0] f_addr(input logic [3:0] idx);
    case (idx)
      4'd0:    return 8'h21;
      4'd1:    return 8'h22;
      4'd2:    return 8'h23;
      4'd3:    return 8'h24;
      4'd4:    return 8'h25;
      4'd5:    return 8'h26;
      4'd6:    return 8'h41;
      4'd7:    return 8'h42;
      4'd8:    return 8'h43;
      default: return 8'hF0;
    endcase
  endfunction

  assign w_start = (r_state == StIdle) && i_do_it_escribir && !r_prev &&
                   (i_sel_grupo != 2'd3);
  assign w_fin_e     = (r_cnt == FinE);
  assign w_fin_p     = (r_cnt == FinP);
  assign w_txn_next  = r_txn + 2'd1;
  assign w_idx_first = f_reg_idx(i_sel_grupo, 2'd0);
  assign w_idx_next  = f_reg_idx(r_grupo, w_txn_next);
  // The command byte depends only on the group; the bank value is ignored there.
  assign w_dato = (r_reg_idx == IdxComando) ?
                  ((r_grupo == 2'd2) ? CmdTimer : CmdFechaHora) : i_dato_reg;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state   <= StIdle;
      r_cnt     <= '0;
      r_txn     <= 2'd0;
      r_grupo   <= 2'd0;
      r_prev    <= 1'b1;
      r_reg_idx <= 4'd0;
      r_a_d     <= 1'b1;
      r_cs      <= 1'b1;
      r_wr      <= 1'b1;
      r_bus     <= 8'h00;
      r_buf     <= 1'b0;
      r_ocupado <= 1'b0;
      r_listo   <= 1'b0;
    end else begin
      r_prev  <= i_do_it_escribir;
      r_listo <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (w_start) begin
            r_state   <= StAddrSetup;
            r_grupo   <= i_sel_grupo;
            r_txn     <= 2'd0;
            r_cnt     <= '0;
            r_ocupado <= 1'b1;
            r_reg_idx <= w_idx_first;
            r_bus     <= f_addr(w_idx_first);
            r_cs      <= 1'b0;
            r_a_d     <= 1'b0;
            r_wr      <= 1'b1;
            r_buf     <= 1'b1;
          end
        end
        StAddrSetup: begin
          if (w_fin_e) begin
            r_state <= StAddrStrobe;
            r_cnt   <= '0;
            r_wr    <= 1'b0;
          end else begin
            r_cnt <= r_cnt + CntW'(1);
          end
        end
        StAddrStrobe: begin
          if (w_fin_p) begin
            r_state <= StAddrHold;
            r_cnt   <= '0;
            r_wr    <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CntW'(1);
          end
        end
        StAddrHold: begin
          if (w_fin_e) begin
            // r_bus doubles as the captured data byte until the gap.
            r_state <= StDataSetup;
            r_cnt   <= '0;
            r_a_d   <= 1'b1;
            r_bus   <= w_dato;
          end else begin
            r_cnt <= r_cnt + CntW'(1);
          end
        end
        StDataSetup: begin
          if (w_fin_e) begin
            r_state <= StDataStrobe;
            r_cnt   <= '0;
            r_wr    <= 1'b0;
          end else begin
            r_cnt <= r_cnt + CntW'(1);
          end
        end
        StDataStrobe: begin
          if (w_fin_p) begin
            r_state <= StDataHold;
            r_cnt   <= '0;
            r_wr    <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CntW'(1);
          end
        end
        StDataHold: begin
          if (w_fin_e) begin
            r_state <= StGap;
            r_cnt   <= '0;
            r_cs    <= 1'b1;
            r_buf   <= 1'b0;
            r_a_d   <= 1'b1;
            r_bus   <= 8'h00;
          end else begin
            r_cnt <= r_cnt + CntW'(1);
          end
        end
        StGap: begin
          if (r_txn == 2'd3) begin
            r_state   <= StIdle;
            r_ocupado <= 1'b0;
            r_listo   <= 1'b1;
          end else begin
            r_state   <= StAddrSetup;
            r_txn     <= w_txn_next;
            r_cnt     <= '0;
            r_reg_idx <= w_idx_next;
            r_bus     <= f_addr(w_idx_next);
            r_cs      <= 1'b0;
            r_a_d     <= 1'b0;
            r_buf     <= 1'b1;
          end
        end
      endcase
    end
  end

  assign o_reg_idx       = r_reg_idx;
  assign o_a_d           = r_a_d;
  assign o_cs            = r_cs;
  assign o_rd            = 1'b1;
  assign o_wr            = r_wr;
  assign o_bus_out       = r_bus;
  assign o_buffer_activo = r_buf;
  assign o_ocupado       = r_ocupado;
  assign o_listo         = r_listo;

endmodule
